// File: rtl/display_ram_arbiter.sv
// Arbitrates the 32x8 character display RAM between NREQ round-robin writers and the LCD refresh reader.
// Optional macro HOLD_TIMEOUT_EN adds a watchdog that revokes a grant held longer than MAX_HOLD cycles.
module display_ram_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ-1:0]          we_in,
  input  logic [NREQ*ADDR_W-1:0]   waddr_in,
  input  logic [NREQ*DATA_W-1:0]   din_in,
  input  logic                     lcd_req,
  input  logic [ADDR_W-1:0]        lcd_addr,
  output logic [NREQ-1:0]          gnt,
  output logic                     lcd_ack,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_dout,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, READ} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] owner, last, winner;
  logic             winner_valid;
  logic             owner_locked;
  logic             timeout_hit;

  assign owner_locked = req[owner] & lock[owner];

  // Round-robin search starting just after the last winner, wrapping modulo NREQ
  always_comb begin
    int idx;
    idx          = 0;
    winner       = '0;
    winner_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!winner_valid && req[idx]) begin
        winner       = IDX_W'(idx);
        winner_valid = 1'b1;
      end
    end
  end

`ifdef HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  assign timeout_hit = (state == GRANT) && owner_locked &&
                       (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= IDX_W'(NREQ - 1);
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == GRANT) begin
        gnt   <= NREQ'(1) << winner;
        owner <= winner;
        last  <= winner;
      end else if (next_state != GRANT) begin
        gnt <= '0;
      end
    end
  end

  // The LCD reader always wins at an arbitration point; writers keep the grant only while locked
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (lcd_req)
          next_state = READ;
        else if (winner_valid)
          next_state = GRANT;
      end
      GRANT: begin
        if (!owner_locked || timeout_hit)
          next_state = IDLE;
      end
      READ:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = lcd_addr;
    ram_we   = 1'b0;
    ram_dout = '0;
    lcd_ack  = 1'b0;
    case (state)
      GRANT: begin
        ram_addr = waddr_in[owner*ADDR_W +: ADDR_W];
        ram_dout = din_in[owner*DATA_W +: DATA_W];
        ram_we   = we_in[owner] & gnt[owner];
      end
      READ:    lcd_ack = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_display_ram_arbiter.sv
// Directed self-checking bench for display_ram_arbiter (NREQ=2, MAX_HOLD=8).
module tb_display_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, lock, we_in;
  logic [9:0]  waddr_in;
  logic [15:0] din_in;
  logic        lcd_req;
  logic [4:0]  lcd_addr;
  logic [1:0]  gnt;
  logic        lcd_ack;
  logic [4:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        busy;
  logic        timeout_err;

  int test_count = 0;
  int fail_count = 0;

  display_ram_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(8), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we_in(we_in),
    .waddr_in(waddr_in), .din_in(din_in), .lcd_req(lcd_req), .lcd_addr(lcd_addr),
    .gnt(gnt), .lcd_ack(lcd_ack), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_dout(ram_dout), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle before checking
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                               input logic [4:0] a0, input logic [7:0] d0,
                               input logic [4:0] a1, input logic [7:0] d1,
                               input logic lr, input logic [4:0] la);
    @(negedge clk);
    req      = r;
    lock     = l;
    we_in    = w;
    waddr_in = {a1, a0};
    din_in   = {d1, d0};
    lcd_req  = lr;
    lcd_addr = la;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    int run_len;
    bit counting;
    int exp_run;
    logic exp_terr;

    reset = 1'b1; req = '0; lock = '0; we_in = '0; waddr_in = '0; din_in = '0;
    lcd_req = 1'b0; lcd_addr = '0;
    #1;
    checkOutput("reset_gnt", gnt, 2'b00);
    checkOutput("reset_ack", lcd_ack, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_we", ram_we, 1'b0);
    checkOutput("reset_terr", timeout_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin rotation with single-cycle grants
    applyStimulus(2'b11, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_idle0", gnt, 2'b00);
    applyStimulus(2'b11, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_gnt0", gnt, 2'b01);
    checkOutput("rot_busy", busy, 1'b1);
    applyStimulus(2'b11, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_idle1", gnt, 2'b00);
    applyStimulus(2'b11, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_gnt1", gnt, 2'b10);
    applyStimulus(2'b11, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_idle2", gnt, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_gnt0_again", gnt, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rot_end_idle", gnt, 2'b00);

    // Writer 0 four-cycle locked burst
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h00, 8'h41, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("burst_idle_we", ram_we, 1'b0);
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h00, 8'h41, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("burst1_gnt", gnt, 2'b01);
    checkOutput("burst1_we", ram_we, 1'b1);
    checkOutput("burst1_addr", ram_addr, 5'h00);
    checkOutput("burst1_data", ram_dout, 8'h41);
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h10, 8'h42, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("burst2_we", ram_we, 1'b1);
    checkOutput("burst2_addr", ram_addr, 5'h10);
    checkOutput("burst2_data", ram_dout, 8'h42);
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h01, 8'h20, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("burst3_addr", ram_addr, 5'h01);
    checkOutput("burst3_data", ram_dout, 8'h20);
    applyStimulus(2'b01, 2'b00, 2'b01, 5'h11, 8'h20, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("burst4_we", ram_we, 1'b1);
    checkOutput("burst4_addr", ram_addr, 5'h11);
    checkOutput("burst4_gnt", gnt, 2'b01);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("burst_end_gnt", gnt, 2'b00);
    checkOutput("burst_end_we", ram_we, 1'b0);

    // LCD beats a simultaneous writer request
    applyStimulus(2'b10, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b1, 5'h05);
    checkOutput("lcd_pre_ack", lcd_ack, 1'b0);
    applyStimulus(2'b10, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h05);
    checkOutput("lcd_ack", lcd_ack, 1'b1);
    checkOutput("lcd_addr", ram_addr, 5'h05);
    checkOutput("lcd_we", ram_we, 1'b0);
    checkOutput("lcd_gnt", gnt, 2'b00);
    applyStimulus(2'b10, 2'b10, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h05);
    checkOutput("lcd_turn_gnt", gnt, 2'b00);
    checkOutput("lcd_turn_ack", lcd_ack, 1'b0);

    // Writer 1 owns; writer 0 tries to write address 0x03
    applyStimulus(2'b11, 2'b10, 2'b11, 5'h03, 8'h5A, 5'h07, 8'h78, 1'b0, 5'h00);
    checkOutput("own1_gnt", gnt, 2'b10);
    checkOutput("own1_addr", ram_addr, 5'h07);
    checkOutput("own1_we", ram_we, 1'b1);
    checkOutput("own1_data", ram_dout, 8'h78);
    applyStimulus(2'b11, 2'b10, 2'b01, 5'h03, 8'h5A, 5'h07, 8'h78, 1'b0, 5'h00);
    checkOutput("own1_nowe", ram_we, 1'b0);
    checkOutput("own1_addr2", ram_addr, 5'h07);
    applyStimulus(2'b01, 2'b00, 2'b01, 5'h03, 8'h5A, 5'h07, 8'h78, 1'b0, 5'h00);
    checkOutput("own1_exit_we", ram_we, 1'b0);
    checkOutput("own1_exit_addr", ram_addr, 5'h07);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("drop_idle", gnt, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("drop_no_grant", gnt, 2'b00);

    // Long lock: watchdog revokes after MAX_HOLD cycles when enabled
`ifdef HOLD_TIMEOUT_EN
    exp_run  = 8;
    exp_terr = 1'b1;
`else
    exp_run  = 20;
    exp_terr = 1'b0;
`endif
    applyStimulus(2'b01, 2'b01, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    run_len  = 0;
    counting = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(2'b01, 2'b01, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
      if (counting && gnt == 2'b01)
        run_len++;
      else
        counting = 1'b0;
    end
    checkOutput("hold_run_len", run_len, exp_run);
    checkOutput("hold_terr", timeout_err, exp_terr);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("hold_released", gnt, 2'b00);
    checkOutput("hold_terr_sticky", timeout_err, exp_terr);

    // Reset in the third cycle of a writer 0 burst
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h09, 8'h31, 5'h00, 8'h00, 1'b0, 5'h00);
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h09, 8'h31, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rst_burst1", gnt, 2'b01);
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h0A, 8'h32, 5'h00, 8'h00, 1'b0, 5'h00);
    applyStimulus(2'b01, 2'b01, 2'b01, 5'h0B, 8'h33, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rst_burst3_we", ram_we, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_gnt", gnt, 2'b00);
    checkOutput("rst_mid_we", ram_we, 1'b0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_terr", timeout_err, 1'b0);
    applyStimulus(2'b11, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 5'h00, 8'h00, 5'h00, 8'h00, 1'b0, 5'h00);
    checkOutput("rst_first_gnt", gnt, 2'b01);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
